// File: rtl/cl_pkg.sv
// Shared types and constants for the Camera Link capture front end.
// Holds the unpack phase and capture state encodings used by the framer.
package cl_pkg;

  localparam int unsigned CL_PIXEL_SIZE = 12;
  localparam int unsigned CL_BUNDLE_W   = 80;
  localparam int unsigned CL_TAP_W      = CL_BUNDLE_W / 2;
  localparam int unsigned CL_GROUP_W    = 4 * CL_PIXEL_SIZE;

  typedef enum logic [1:0] {
    CL_0,
    CL_1,
    CL_2,
    CL_INTERLINE
  } cl_state_e;

  typedef enum logic [1:0] {
    CapIdle,
    CapArmed,
    CapCapturing
  } cap_state_e;

  // Phase sequence while LVAL is high; INTERLINE behaves like PH0.
  function automatic cl_state_e cl_next_phase(cl_state_e cur);
    cl_state_e nxt;
    unique case (cur)
      CL_INTERLINE, CL_0: nxt = CL_1;
      CL_1:               nxt = CL_2;
      CL_2:               nxt = CL_0;
      default:            nxt = CL_1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cl_tap_unpacker.sv
// Unpacks one 40-bit Camera Link tap into 3 or 4 packed 12-bit pixels per clock.
// Phase comes from the parent so both taps stay in lockstep.
module cl_tap_unpacker
  import cl_pkg::*;
(
  input  logic                  clk_85,
  input  logic                  reset,
  input  logic                  lval,
  input  cl_state_e             phase,
  input  logic [CL_TAP_W-1:0]   data,
  output logic [CL_GROUP_W-1:0] pixels
);

  logic [7:0] hold_q, hold_d;
  logic [7:0] pa, pb, pc, pd, pe;

  assign pa = data[39:32];
  assign pb = data[31:24];
  assign pc = data[23:16];
  assign pd = data[15:8];
  assign pe = data[7:0];

  always_comb begin
    hold_d = hold_q;
    pixels = '0;
    if (!lval) begin
      // Leftover bits never carry across a line boundary.
      hold_d = '0;
    end else begin
      unique case (phase)
        CL_INTERLINE, CL_0: begin
          pixels = {pa, pb, pc, pd, pe[7:4], 12'h000};
          hold_d = {4'h0, pe[3:0]};
        end
        CL_1: begin
          pixels = {hold_q[3:0], pa, pb, pc, pd, 12'h000};
          hold_d = pe;
        end
        CL_2: begin
          pixels = {hold_q, pa, pb, pc, pd, pe};
          hold_d = '0;
        end
        default: begin
          pixels = '0;
          hold_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/cl_line_framer.sv
// Camera Link Full front end: unpacks two taps into tagged pixel groups,
// gates whole frames on a capture request and checks line/frame geometry.
module cl_line_framer
  import cl_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE  = 12,
  parameter int unsigned N_COL_SIZE  = 12,
  parameter int unsigned N_ROW_SIZE  = 11,
  parameter int unsigned LINE_PIXELS = 2560,
  parameter int unsigned FRAME_ROWS  = 1080
) (
  input  logic                    clk_85,
  input  logic                    reset,
  input  logic                    cl_fval,
  input  logic                    cl_lval,
  input  logic [7:0]              cl_port_a,
  input  logic [7:0]              cl_port_b,
  input  logic [7:0]              cl_port_c,
  input  logic [7:0]              cl_port_d,
  input  logic [7:0]              cl_port_e,
  input  logic [7:0]              cl_port_f,
  input  logic [7:0]              cl_port_g,
  input  logic [7:0]              cl_port_h,
  input  logic [7:0]              cl_port_i,
  input  logic [7:0]              cl_port_j,
  input  logic                    capture_en,
  output logic [4*PIXEL_SIZE-1:0] pixel_top,
  output logic [4*PIXEL_SIZE-1:0] pixel_btm,
  output logic                    pixel012_valid,
  output logic                    pixel3_valid,
  output logic [N_COL_SIZE-1:0]   l_col,
  output logic [N_COL_SIZE-1:0]   r_col,
  output logic [N_ROW_SIZE-1:0]   row,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic                    line_err,
  output logic                    frame_err,
  output logic                    capturing
);

  localparam logic [N_COL_SIZE:0]   LinePix  = (N_COL_SIZE + 1)'(LINE_PIXELS);
  localparam logic [N_ROW_SIZE-1:0] FrameRow = N_ROW_SIZE'(FRAME_ROWS);

  logic [CL_BUNDLE_W-1:0] bundle;
  logic [CL_GROUP_W-1:0]  pix_top, pix_btm;

  cl_state_e  st_q, st_d;
  cap_state_e cap_q, cap_d;
  logic       fval_q, lval_q;
  logic       fval_rise, fval_fall, lval_fall;
  logic       four, show;

  logic [N_COL_SIZE-1:0] rcol_q, rcol_d, lcol_n, rcol_n, span;
  logic [N_COL_SIZE:0]   cnt_q, cnt_d;
  logic [N_COL_SIZE+1:0] cnt_sum;
  logic [N_ROW_SIZE-1:0] row_q, row_d;
  logic                  fs_d, fe_d, lerr_d, ferr_d;

  assign bundle = {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
                   cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j};

  cl_tap_unpacker u_top (
    .clk_85 (clk_85),
    .reset  (reset),
    .lval   (cl_lval),
    .phase  (st_q),
    .data   (bundle[CL_BUNDLE_W-1:CL_TAP_W]),
    .pixels (pix_top)
  );

  cl_tap_unpacker u_btm (
    .clk_85 (clk_85),
    .reset  (reset),
    .lval   (cl_lval),
    .phase  (st_q),
    .data   (bundle[CL_TAP_W-1:0]),
    .pixels (pix_btm)
  );

  assign fval_rise = cl_fval & ~fval_q;
  assign fval_fall = ~cl_fval & fval_q;
  assign lval_fall = ~cl_lval & lval_q;
  assign four      = cl_lval & (st_q == CL_2);

  // Unpack phase, column tags and line pixel count.
  always_comb begin
    st_d    = cl_lval ? cl_next_phase(st_q) : CL_INTERLINE;
    span    = four ? N_COL_SIZE'(3) : N_COL_SIZE'(2);
    lcol_n  = (st_q == CL_INTERLINE) ? '0 : rcol_q + 1'b1;
    rcol_n  = lcol_n + span;
    rcol_d  = cl_lval ? rcol_n : '1;
    cnt_sum = {1'b0, cnt_q} + (N_COL_SIZE + 2)'(four ? 4 : 3);
    cnt_d   = '0;
    if (cl_lval) begin
      cnt_d = cnt_sum[N_COL_SIZE+1] ? '1 : cnt_sum[N_COL_SIZE:0];
    end
  end

  // Row counter; a line that ends together with FVAL still counts.
  always_comb begin
    row_d = row_q;
    if (fval_rise) begin
      row_d = '0;
    end else if (lval_fall && (cl_fval || fval_q) && (row_q != '1)) begin
      row_d = row_q + 1'b1;
    end
  end

  always_comb begin
    cap_d = cap_q;
    fs_d  = 1'b0;
    fe_d  = 1'b0;
    unique case (cap_q)
      CapIdle: begin
        if (capture_en) cap_d = CapArmed;
      end
      CapArmed: begin
        if (fval_rise) begin
          cap_d = CapCapturing;
          fs_d  = 1'b1;
        end
      end
      CapCapturing: begin
        if (fval_fall) begin
          cap_d = CapIdle;
          fe_d  = 1'b1;
        end
      end
      default: cap_d = CapIdle;
    endcase
    lerr_d = lval_fall && (cap_q == CapCapturing) && ((cnt_q != LinePix) || (st_q != CL_0));
    ferr_d = fe_d && (row_d != FrameRow);
    show   = cl_lval && (cap_d == CapCapturing);
  end

  assign row = row_q;

  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      st_q           <= CL_INTERLINE;
      cap_q          <= CapIdle;
      // Treat FVAL as already high so a frame in progress at reset release never looks like a rise.
      fval_q         <= 1'b1;
      lval_q         <= 1'b0;
      rcol_q         <= '1;
      cnt_q          <= '0;
      row_q          <= '0;
      pixel_top      <= '0;
      pixel_btm      <= '0;
      pixel012_valid <= 1'b0;
      pixel3_valid   <= 1'b0;
      l_col          <= '1;
      r_col          <= '1;
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
      line_err       <= 1'b0;
      frame_err      <= 1'b0;
      capturing      <= 1'b0;
    end else begin
      st_q           <= st_d;
      cap_q          <= cap_d;
      fval_q         <= cl_fval;
      lval_q         <= cl_lval;
      rcol_q         <= rcol_d;
      cnt_q          <= cnt_d;
      row_q          <= row_d;
      pixel_top      <= show ? pix_top : '0;
      pixel_btm      <= show ? pix_btm : '0;
      pixel012_valid <= show;
      pixel3_valid   <= show & four;
      l_col          <= show ? lcol_n : '1;
      r_col          <= show ? rcol_n : '1;
      frame_start    <= fs_d;
      frame_end      <= fe_d;
      line_err       <= lerr_d;
      frame_err      <= ferr_d;
      capturing      <= (cap_d == CapCapturing);
    end
  end

endmodule

// File: tb/tb_cl_line_framer.sv
// Bench for cl_line_framer: bit-stream reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_cl_line_framer;

  localparam int unsigned LinePixels = 20;
  localparam int unsigned FrameRows  = 4;

  logic clk_85 = 1'b0;
  logic reset;
  logic cl_fval, cl_lval, capture_en;
  logic [7:0] cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e;
  logic [7:0] cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j;
  logic [47:0] pixel_top, pixel_btm;
  logic pixel012_valid, pixel3_valid;
  logic [11:0] l_col, r_col;
  logic [10:0] row;
  logic frame_start, frame_end, line_err, frame_err, capturing;

  cl_line_framer #(
    .PIXEL_SIZE  (12),
    .N_COL_SIZE  (12),
    .N_ROW_SIZE  (11),
    .LINE_PIXELS (LinePixels),
    .FRAME_ROWS  (FrameRows)
  ) dut (
    .clk_85         (clk_85),
    .reset          (reset),
    .cl_fval        (cl_fval),
    .cl_lval        (cl_lval),
    .cl_port_a      (cl_port_a),
    .cl_port_b      (cl_port_b),
    .cl_port_c      (cl_port_c),
    .cl_port_d      (cl_port_d),
    .cl_port_e      (cl_port_e),
    .cl_port_f      (cl_port_f),
    .cl_port_g      (cl_port_g),
    .cl_port_h      (cl_port_h),
    .cl_port_i      (cl_port_i),
    .cl_port_j      (cl_port_j),
    .capture_en     (capture_en),
    .pixel_top      (pixel_top),
    .pixel_btm      (pixel_btm),
    .pixel012_valid (pixel012_valid),
    .pixel3_valid   (pixel3_valid),
    .l_col          (l_col),
    .r_col          (r_col),
    .row            (row),
    .frame_start    (frame_start),
    .frame_end      (frame_end),
    .line_err       (line_err),
    .frame_err      (frame_err),
    .capturing      (capturing)
  );

  always #5 clk_85 = ~clk_85;

  int n_tests, n_fail;

  // Reference model state: per-tap bit queues consumed 12 bits per pixel.
  bit tq[$];
  bit bq[$];
  int m_px, m_cyc, m_row;
  bit m_armed, m_cap, m_fprev, m_lprev;
  logic [47:0] e_top, e_btm;
  logic e_v012, e_v3, e_fs, e_fe, e_lerr, e_ferr, e_capt;
  logic [11:0] e_l, e_r;
  logic [10:0] e_row;

  // Recorder
  int rec_l[$], rec_r[$], rec_v3[$];
  logic [47:0] rec_top[$], rec_btm[$];
  int n_fs, n_fe, n_lerr, n_lerr_col, n_ferr, n_ferr_fe;
  int s_grp, s_fs, s_fe, s_lerr, s_lerr_col, s_ferr, s_ferr_fe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tq.delete(); bq.delete();
    m_px = 0; m_cyc = 0; m_row = 0;
    m_armed = 0; m_cap = 0; m_fprev = 1; m_lprev = 0;
    e_top = '0; e_btm = '0; e_v012 = 0; e_v3 = 0;
    e_l = '1; e_r = '1; e_row = '0;
    e_fs = 0; e_fe = 0; e_lerr = 0; e_ferr = 0; e_capt = 0;
  endtask

  task automatic model_step();
    bit rise, fall, lfall;
    int g;
    logic [39:0] wt, wb;
    rise  = cl_fval && !m_fprev;
    fall  = !cl_fval && m_fprev;
    lfall = !cl_lval && m_lprev;
    e_fs = 0; e_fe = 0; e_lerr = 0; e_ferr = 0;
    if (lfall && m_cap && (m_px != LinePixels || m_cyc % 3 != 0)) e_lerr = 1;
    if (rise) m_row = 0;
    else if (lfall && (cl_fval || m_fprev) && m_row < 2047) m_row++;
    if (m_cap) begin
      if (fall) begin m_cap = 0; e_fe = 1; e_ferr = (m_row != FrameRows); end
    end else if (m_armed) begin
      if (rise) begin m_armed = 0; m_cap = 1; e_fs = 1; end
    end else if (capture_en) begin
      m_armed = 1;
    end
    e_top = '0; e_btm = '0; e_v012 = 0; e_v3 = 0; e_l = '1; e_r = '1;
    if (cl_lval) begin
      wt = {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e};
      wb = {cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j};
      for (int i = 39; i >= 0; i--) begin tq.push_back(wt[i]); bq.push_back(wb[i]); end
      g = (m_cyc % 3 == 2) ? 4 : 3;
      if (m_cap) begin
        e_v012 = 1; e_v3 = (g == 4);
        e_l = 12'(m_px); e_r = 12'(m_px + g - 1);
        for (int i = 0; i < 12 * g; i++) begin e_top[47-i] = tq[i]; e_btm[47-i] = bq[i]; end
      end
      for (int i = 0; i < 12 * g; i++) begin void'(tq.pop_front()); void'(bq.pop_front()); end
      m_px += g; m_cyc++;
    end else begin
      tq.delete(); bq.delete(); m_px = 0; m_cyc = 0;
    end
    e_row = 11'(m_row); e_capt = m_cap;
    m_fprev = cl_fval; m_lprev = cl_lval;
  endtask

  task automatic compare_cycle();
    check("pixel_top", 64'(pixel_top), 64'(e_top));
    check("pixel_btm", 64'(pixel_btm), 64'(e_btm));
    check("pixel012_valid", 64'(pixel012_valid), 64'(e_v012));
    check("pixel3_valid", 64'(pixel3_valid), 64'(e_v3));
    check("l_col", 64'(l_col), 64'(e_l));
    check("r_col", 64'(r_col), 64'(e_r));
    check("row", 64'(row), 64'(e_row));
    check("frame_start", 64'(frame_start), 64'(e_fs));
    check("frame_end", 64'(frame_end), 64'(e_fe));
    check("line_err", 64'(line_err), 64'(e_lerr));
    check("frame_err", 64'(frame_err), 64'(e_ferr));
    check("capturing", 64'(capturing), 64'(e_capt));
    if (pixel012_valid === 1'b1) begin
      rec_l.push_back(int'(l_col)); rec_r.push_back(int'(r_col));
      rec_v3.push_back(int'(pixel3_valid));
      rec_top.push_back(pixel_top); rec_btm.push_back(pixel_btm);
    end
    if (frame_start === 1'b1) n_fs++;
    if (frame_end === 1'b1) n_fe++;
    if (line_err === 1'b1) begin n_lerr++; if (l_col === 12'hfff) n_lerr_col++; end
    if (frame_err === 1'b1) begin n_ferr++; if (frame_end === 1'b1) n_ferr_fe++; end
  endtask

  task automatic snap();
    s_grp = rec_l.size(); s_fs = n_fs; s_fe = n_fe; s_lerr = n_lerr;
    s_lerr_col = n_lerr_col; s_ferr = n_ferr; s_ferr_fe = n_ferr_fe;
  endtask

  // 20-pixel ramp starting at base, packed MSB first; returns 40-bit word k.
  function automatic logic [39:0] tap_word(input int base, input int k);
    logic [239:0] s;
    s = '0;
    for (int i = 0; i < 20; i++) s[239-12*i -: 12] = 12'(base + i);
    return s[239-40*k -: 40];
  endfunction

  task automatic cyc(input bit f, input bit l, input logic [39:0] t, input logic [39:0] b);
    cl_fval = f; cl_lval = l;
    {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e} = t;
    {cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j} = b;
    @(posedge clk_85); #1;
  endtask

  task automatic send_line(input int ncyc, input int gap);
    for (int k = 0; k < ncyc; k++) cyc(1, 1, tap_word(1, k % 6), tap_word(12'h101, k % 6));
    for (int k = 0; k < gap; k++) cyc(1, 0, '0, '0);
  endtask

  task automatic send_frame(input int nl, input int short_idx, input int cen_line, input bit cen_val);
    cyc(1, 0, '0, '0);
    cyc(1, 0, '0, '0);
    for (int i = 0; i < nl; i++) begin
      if (i == cen_line) capture_en = cen_val;
      send_line((i == short_idx) ? 2 : 6, 5);
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, '0);
  endtask

  initial begin
    int pv;
    n_tests = 0; n_fail = 0;
    n_fs = 0; n_fe = 0; n_lerr = 0; n_lerr_col = 0; n_ferr = 0; n_ferr_fe = 0;
    model_reset();
    reset = 1'b0; capture_en = 1'b0; cl_fval = 1'b0; cl_lval = 1'b0;
    {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e} = '0;
    {cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j} = '0;
    #2 reset = 1'b1;
    fork
      forever begin
        @(posedge clk_85 or posedge reset);
        if (reset) model_reset(); else model_step();
      end
      forever begin
        @(negedge clk_85);
        compare_cycle();
      end
    join_none
    #2;
    check("reset_pixel_top", 64'(pixel_top), 64'h0);
    check("reset_l_col", 64'(l_col), 64'hfff);
    check("reset_r_col", 64'(r_col), 64'hfff);
    check("reset_row", 64'(row), 64'h0);
    check("reset_capturing", 64'(capturing), 64'h0);
    @(posedge clk_85); @(posedge clk_85); #1 reset = 1'b0;
    cyc(0, 0, '0, '0);

    // Ramp frame, 4 full lines with 5-cycle interline gaps.
    capture_en = 1'b1;
    cyc(0, 0, '0, '0); cyc(0, 0, '0, '0);
    snap();
    send_frame(4, -1, -1, 1'b0);
    check("ramp_groups", 64'(rec_l.size() - s_grp), 64'd24);
    if (rec_l.size() - s_grp >= 7) begin
      int exp_l[6] = '{0, 3, 6, 10, 13, 16};
      int exp_r[6] = '{2, 5, 9, 12, 15, 19};
      pv = 1;
      for (int j = 0; j < 6; j++) begin
        int np;
        logic [47:0] w;
        check("ramp_l_col", 64'(rec_l[s_grp+j]), 64'(exp_l[j]));
        check("ramp_r_col", 64'(rec_r[s_grp+j]), 64'(exp_r[j]));
        np = (rec_v3[s_grp+j] != 0) ? 4 : 3;
        w = rec_top[s_grp+j];
        for (int k = 0; k < np; k++) begin
          check("ramp_pixel", 64'(w[47-12*k -: 12]), 64'(pv));
          pv++;
        end
      end
      check("ramp_pixel_count", 64'(pv - 1), 64'd20);
      w_btm_check: begin
        logic [47:0] wb;
        wb = rec_btm[s_grp];
        check("ramp_btm_first", 64'(wb[47:36]), 64'h101);
      end
      check("line2_l_col", 64'(rec_l[s_grp+6]), 64'd0);
      w_line2: begin
        logic [47:0] w2;
        w2 = rec_top[s_grp+6];
        check("line2_first_pixel", 64'(w2), 64'h001002003000);
      end
    end
    check("ramp_line_err", 64'(n_lerr - s_lerr), 64'd0);
    check("ramp_frame_err", 64'(n_ferr - s_ferr), 64'd0);
    check("ramp_frame_start", 64'(n_fs - s_fs), 64'd1);
    check("ramp_frame_end", 64'(n_fe - s_fe), 64'd1);

    // Only 3 lines against FRAME_ROWS=4.
    snap();
    send_frame(3, -1, -1, 1'b0);
    check("rows3_frame_err", 64'(n_ferr - s_ferr), 64'd1);
    check("rows3_err_with_end", 64'(n_ferr_fe - s_ferr_fe), 64'd1);
    check("rows3_frame_end", 64'(n_fe - s_fe), 64'd1);

    // Short second line; capture_en dropped mid-frame must not cut the frame.
    snap();
    send_frame(4, 1, 2, 1'b0);
    check("short_line_err", 64'(n_lerr - s_lerr), 64'd1);
    check("short_l_col_ones", 64'(n_lerr_col - s_lerr_col), 64'd1);
    check("short_groups", 64'(rec_l.size() - s_grp), 64'd20);
    check("short_frame_err", 64'(n_ferr - s_ferr), 64'd0);
    check("short_capturing", 64'(capturing), 64'd0);

    // capture_en raised mid-frame: nothing captured this frame.
    snap();
    send_frame(4, -1, 2, 1'b1);
    check("late_groups", 64'(rec_l.size() - s_grp), 64'd0);
    check("late_frame_start", 64'(n_fs - s_fs), 64'd0);
    check("late_frame_end", 64'(n_fe - s_fe), 64'd0);
    snap();
    send_frame(4, -1, -1, 1'b0);
    check("next_frame_start", 64'(n_fs - s_fs), 64'd1);
    check("next_groups", 64'(rec_l.size() - s_grp), 64'd24);
    check("next_frame_end", 64'(n_fe - s_fe), 64'd1);
    check("next_capturing", 64'(capturing), 64'd0);

    // Asynchronous reset while the unpacker sits in PH2.
    cyc(1, 0, '0, '0); cyc(1, 0, '0, '0);
    cyc(1, 1, tap_word(1, 0), tap_word(12'h101, 0));
    cyc(1, 1, tap_word(1, 1), tap_word(12'h101, 1));
    check("pre_reset_capturing", 64'(capturing), 64'd1);
    {cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e} = tap_word(1, 2);
    {cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j} = tap_word(12'h101, 2);
    reset = 1'b1;
    #1;
    check("rst_pixel_top", 64'(pixel_top), 64'h0);
    check("rst_valid", 64'(pixel012_valid), 64'h0);
    check("rst_l_col", 64'(l_col), 64'hfff);
    check("rst_row", 64'(row), 64'h0);
    check("rst_capturing", 64'(capturing), 64'h0);
    @(posedge clk_85); #1 reset = 1'b0;
    snap();
    cyc(1, 0, '0, '0);
    send_line(6, 5); send_line(6, 5); send_line(6, 5);
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, '0);
    check("post_rst_groups", 64'(rec_l.size() - s_grp), 64'd0);
    check("post_rst_frame_start", 64'(n_fs - s_fs), 64'd0);
    check("post_rst_frame_end", 64'(n_fe - s_fe), 64'd0);
    snap();
    send_frame(4, -1, -1, 1'b0);
    check("fresh_frame_start", 64'(n_fs - s_fs), 64'd1);
    check("fresh_groups", 64'(rec_l.size() - s_grp), 64'd24);
    check("fresh_line_err", 64'(n_lerr - s_lerr), 64'd0);

    cyc(0, 0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
